// File: rtl/param_mem_arbiter.sv
// Two-port to one-port memory arbiter: round-robin or fixed priority (port 1) on requests,
// in-order response routing through a small FIFO of requester IDs.
module param_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit FIXED_PRIO      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] req0_msg,
    input  logic        req0_val,
    output logic        req0_rdy,
    output logic [34:0] resp0_msg,
    output logic        resp0_val,
    input  logic [66:0] req1_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [34:0] resp1_msg,
    output logic        resp1_val,
    output logic [66:0] memreq_msg,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic [34:0] memresp_msg,
    input  logic        memresp_val,
    output logic        err_unexp_resp
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    logic [MAX_OUTSTANDING-1:0] tags_q, tags_d;
    logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       last_grant_q, last_grant_d;
    logic                       err_q, err_d;

    logic full, grant, fire, pop, head_id;

    // Request side: fullness looks only at the registered count, so a pop never frees a slot early.
    always_comb begin
        full = (cnt_q == CW'(MAX_OUTSTANDING));
        if (req0_val && !req1_val)
            grant = 1'b0;
        else if (req1_val && !req0_val)
            grant = 1'b1;
        else if (FIXED_PRIO)
            grant = 1'b1;
        else
            grant = ~last_grant_q;
        memreq_val = (req0_val | req1_val) & ~full;
        memreq_msg = memreq_val ? (grant ? req1_msg : req0_msg) : '0;
        req0_rdy   = ~grant & memreq_rdy & ~full;
        req1_rdy   =  grant & memreq_rdy & ~full;
        fire       = memreq_val & memreq_rdy;
    end

    // Response side: the oldest outstanding tag steers the response.
    always_comb begin
        pop       = memresp_val & (cnt_q != '0);
        head_id   = tags_q[head_q];
        resp0_val = pop & ~head_id;
        resp1_val = pop &  head_id;
        resp0_msg = memresp_msg;
        resp1_msg = memresp_msg;
    end

    always_comb begin
        tags_d       = tags_q;
        tail_d       = tail_q;
        head_d       = head_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            tags_d[tail_q] = grant;
            tail_d         = tail_q + PW'(1);
            last_grant_d   = grant;
        end
        if (pop)
            head_d = head_q + PW'(1);
        cnt_d = cnt_q + CW'(fire) - CW'(pop);
        err_d = err_q | (memresp_val & (cnt_q == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            tags_q       <= tags_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign err_unexp_resp = err_q;

endmodule
